datapath_sequencer: RTL and testbench

- Multi-cycle instruction sequencer driving the 16-register / ALU datapath.
- Fetches 32-bit instruction words over a simple memory handshake, holds them in an internal IR, and presents the register-select and opcode fields to the datapath.
- Generates the per-register write strobes, holding mul/div operations for a fixed ALU latency.
- Sits between instruction memory and the register file/ALU; sole owner of all datapath write enables.

---
 rtl/datapath_sequencer.sv | 145 ++++++++++++++
 tb/tb_datapath_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-register ALU datapath.
// Owns every datapath write enable; strobes come straight from flops so they cannot glitch.
module datapath_sequencer #(
  parameter int unsigned PC_W          = 16,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     ir,
  output logic [4:0]      alu_op,
  output logic [3:0]      sel_a,
  output logic [3:0]      sel_b,
  output logic [14:0]     imm,
  output logic            use_imm,
  output logic [15:0]     reg_we,
  output logic            hi_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StWaitMd, StWb, StHalt
  } state_e;

  localparam logic [4:0]      OpMul  = 5'b01100;
  localparam logic [4:0]      OpDiv  = 5'b01101;
  localparam logic [4:0]      OpNop  = 5'b11110;
  localparam logic [4:0]      OpHalt = 5'b11111;
  localparam logic [3:0]      MdLast = 4'(MULDIV_CYCLES - 1);
  localparam logic [PC_W-1:0] PcOne  = {{(PC_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       reg_we_q, reg_we_d;
  logic              hi_we_q, hi_we_d;
  logic [4:0]        alu_op_q, alu_op_d;
  logic              mem_rd_q, busy_q, halted_q;

  logic [4:0] op_q, op_d;
  logic       md_q, md_d;

  assign op_q = ir_q[31:27];
  assign md_q = (op_q == OpMul) || (op_q == OpDiv);
  assign op_d = ir_d[31:27];
  assign md_d = (op_d == OpMul) || (op_d == OpDiv);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PcOne;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op_q == OpHalt)     state_d = StHalt;
        else if (op_q == OpNop) state_d = StWb;
        else                    state_d = StExec;
      end
      StExec: begin
        if (md_q && (MULDIV_CYCLES > 1)) begin
          cnt_d   = MdLast;
          state_d = StWaitMd;
        end else begin
          state_d = StWb;
        end
      end
      // Counter reaches zero on the edge that leaves for WB.
      StWaitMd: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StWb;
      end
      StWb:     state_d = run ? StFetch : StIdle;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    reg_we_d = '0;
    hi_we_d  = 1'b0;
    alu_op_d = '0;
    if (state_d inside {StExec, StWaitMd, StWb}) alu_op_d = op_d;
    if ((state_d == StWb) && (op_d != OpNop)) begin
      if (ir_d[26:23] != 4'd0) reg_we_d[ir_d[26:23]] = 1'b1;
      hi_we_d = md_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      ir_q     <= '0;
      cnt_q    <= '0;
      reg_we_q <= '0;
      hi_we_q  <= 1'b0;
      alu_op_q <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      reg_we_q <= reg_we_d;
      hi_we_q  <= hi_we_d;
      alu_op_q <= alu_op_d;
      mem_rd_q <= (state_d == StFetch);
      busy_q   <= !((state_d == StIdle) || (state_d == StHalt));
      halted_q <= (state_d == StHalt);
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign alu_op   = alu_op_q;
  assign sel_a    = ir_q[22:19];
  assign sel_b    = ir_q[18:15];
  assign imm      = ir_q[14:0];
  assign use_imm  = ir_q[31];
  assign reg_we   = reg_we_q;
  assign hi_we    = hi_we_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomised bench for datapath_sequencer: an instruction-level model predicts every
// cycle's outputs, and a negedge process compares them against the DUT.
module tb_datapath_sequencer;

  localparam int unsigned PC_W = 4;
  localparam int unsigned MD   = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic            run;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [31:0]     mem_rdata;
  logic [31:0]     ir;
  logic [4:0]      alu_op;
  logic [3:0]      sel_a, sel_b;
  logic [14:0]     imm;
  logic            use_imm;
  logic [15:0]     reg_we;
  logic            hi_we;
  logic [PC_W-1:0] pc;
  logic            busy, halted;

  datapath_sequencer #(.PC_W(PC_W), .MULDIV_CYCLES(MD)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .alu_op(alu_op),
    .sel_a(sel_a), .sel_b(sel_b), .imm(imm), .use_imm(use_imm), .reg_we(reg_we),
    .hi_we(hi_we), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state and per-cycle expectations.
  int          m_pc;
  logic [31:0] m_ir;
  logic        exp_rd, exp_hi, exp_busy, exp_halted;
  logic [4:0]  exp_alu;
  logic [15:0] exp_we;
  logic        chk_en = 1'b0;

  // Strobe / read observation log used by the literal checks.
  logic [15:0] last_we;
  logic        last_hi;
  int          last_we_cyc;
  int          rd_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reg_we != 16'd0) begin
      last_we     = reg_we;
      last_hi     = hi_we;
      last_we_cyc = cyc;
    end
    if (mem_rd) rd_cnt++;
    if (chk_en) begin
      chk("mem_rd", mem_rd, exp_rd);
      chk("mem_addr", mem_addr, m_pc[PC_W-1:0]);
      chk("pc", pc, m_pc[PC_W-1:0]);
      chk("ir", ir, m_ir);
      chk("sel_a", sel_a, m_ir[22:19]);
      chk("sel_b", sel_b, m_ir[18:15]);
      chk("imm", imm, m_ir[14:0]);
      chk("use_imm", use_imm, m_ir[31]);
      chk("alu_op", alu_op, exp_alu);
      chk("reg_we", reg_we, exp_we);
      chk("hi_we", hi_we, exp_hi);
      chk("busy", busy, exp_busy);
      chk("halted", halted, exp_halted);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rd, input logic [4:0] alu, input logic [15:0] we,
                         input logic hi, input logic bsy, input logic hlt);
    exp_rd = rd; exp_alu = alu; exp_we = we; exp_hi = hi; exp_busy = bsy; exp_halted = hlt;
  endtask

  // Inputs the sequencer must ignore in the current cycle.
  task automatic junk();
    run       = 1'($urandom_range(0, 1));
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  task automatic idle_cycle(input logic run_v);
    set_exp(0, 0, 0, 0, 0, 0);
    junk();
    run = run_v;
    tick();
  endtask

  // One whole instruction starting in its first FETCH cycle.
  task automatic exec_instr(input logic [31:0] w, input int delay, input logic run_wb,
                            output logic is_halt);
    logic [4:0]  op;
    logic        md, nop;
    logic [15:0] we;
    op  = w[31:27];
    md  = (op == 5'b01100) || (op == 5'b01101);
    nop = (op == 5'b11110);
    for (int i = 0; i <= delay; i++) begin
      set_exp(1, 0, 0, 0, 1, 0);
      junk();
      mem_ack   = (i == delay);
      mem_rdata = (i == delay) ? w : $urandom;
      tick();
    end
    m_ir = w;
    m_pc = (m_pc + 1) % (1 << PC_W);
    set_exp(0, 0, 0, 0, 1, 0);
    junk();
    tick();
    is_halt = (op == 5'b11111);
    if (is_halt) return;
    if (!nop) begin
      for (int i = 0; i < (md ? MD : 1); i++) begin
        set_exp(0, op, 0, 0, 1, 0);
        junk();
        tick();
      end
    end
    we = (nop || w[26:23] == 4'd0) ? 16'd0 : (16'd1 << w[26:23]);
    set_exp(0, op, we, md, 1, 0);
    junk();
    run = run_wb;
    tick();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0:       w[31:27] = 5'b01100;
      1:       w[31:27] = 5'b01101;
      2:       w[31:27] = 5'b11110;
      default: if (w[31:27] == 5'b11111) w[31:27] = 5'b00010;
    endcase
    return w;
  endfunction

  initial begin
    int   start, saved_pc;
    logic h, rwb;

    clr = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    m_pc = 0; m_ir = '0;
    set_exp(0, 0, 0, 0, 0, 0);
    last_we = '0; last_hi = 1'b0; last_we_cyc = -1; rd_cnt = 0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    clr = 1'b1;
    for (int i = 0; i < 10; i++) idle_cycle(1'b0);

    // Add r5 = r1 + r8, zero-wait.
    idle_cycle(1'b1);
    start = cyc;
    exec_instr(32'h0A8C_0000, 0, 1'b1, h);
    chk("add_we_lit", last_we, 16'h0020);
    chk("add_we_cycle", last_we_cyc - start, 3);
    chk("add_hi_lit", last_hi, 1'b0);
    chk("add_pc_lit", pc, 1);
    chk("add_next_fetch_lit", {mem_rd, 4'(mem_addr)}, {1'b1, 4'd1});

    // Mul into r3.
    start = cyc;
    exec_instr(32'h6198_0000, 0, 1'b1, h);
    chk("mul_we_lit", last_we, 16'h0008);
    chk("mul_hi_lit", last_hi, 1'b1);
    chk("mul_we_cycle", last_we_cyc - start, 6);

    // Destination r0, then nop: no strobes either way.
    last_we_cyc = -1;
    exec_instr(32'h0800_1234, 0, 1'b1, h);
    exec_instr(32'hF000_0000, 0, 1'b0, h);
    chk("r0_nop_no_strobe", last_we_cyc, -1);
    chk("nop_pc_lit", pc, 4);

    // Randomised instruction stream with stalls and run toggling.
    rwb = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (!rwb) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) idle_cycle(1'b0);
        idle_cycle(1'b1);
      end
      rwb = 1'($urandom_range(0, 3) != 0);
      exec_instr(rand_word(), $urandom_range(0, 3), rwb, h);
    end
    if (rwb) begin
      // Land in IDLE so the wrap test starts from a known boundary.
      exec_instr(32'hF000_0000, 0, 1'b0, h);
    end

    // Stalled fetch at the top address wraps pc to 0.
    idle_cycle(1'b1);
    while (m_pc != 15) exec_instr(32'hF000_0000, 0, 1'b1, h);
    rd_cnt = 0;
    exec_instr(32'h1100_0005, 3, 1'b0, h);
    chk("stall_rd_cycles", rd_cnt, 4);
    chk("wrap_pc_lit", pc, 0);

    // Halt: frozen until clr.
    idle_cycle(1'b1);
    exec_instr(32'hF800_0000, 1, 1'b0, h);
    saved_pc = m_pc;
    for (int i = 0; i < 8; i++) begin
      set_exp(0, 0, 0, 0, 0, 1);
      junk();
      tick();
    end
    chk("halt_flag_lit", halted, 1'b1);
    chk("halt_pc_frozen", pc, saved_pc);
    chk("halt_no_rd", mem_rd, 1'b0);

    // Async clear out of HALT, then again in the middle of a mul.
    clr = 1'b0; m_pc = 0; m_ir = '0;
    set_exp(0, 0, 0, 0, 0, 0);
    tick();
    clr = 1'b1;
    idle_cycle(1'b1);
    set_exp(1, 0, 0, 0, 1, 0);
    junk(); mem_ack = 1'b1; mem_rdata = 32'h6198_0000;
    tick();
    m_ir = 32'h6198_0000; m_pc = 1;
    set_exp(0, 0, 0, 0, 1, 0);
    junk();
    tick();
    for (int i = 0; i < 2; i++) begin
      set_exp(0, 5'b01100, 0, 0, 1, 0);
      junk();
      tick();
    end
    last_we_cyc = -1;
    #2;
    clr = 1'b0; m_pc = 0; m_ir = '0;
    set_exp(0, 0, 0, 0, 0, 0);
    #1;
    chk("clr_busy_now", busy, 1'b0);
    chk("clr_we_now", reg_we, 16'd0);
    chk("clr_pc_now", pc, 0);
    chk("clr_ir_now", ir, 32'd0);
    for (int i = 0; i < 5; i++) begin
      junk();
      tick();
    end
    clr = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle(1'b0);
    chk("clr_no_strobe", last_we_cyc, -1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
